uart_tx_arbiter: RTL and testbench

- Round-robin scheduler that shares one UART transmitter between N_REQ requesters.
- Grants one requester at a time and issues a one-cycle start pulse with the latched byte.
- Waits for the transmitter's end-of-frame pulse, then enforces an idle gap counted in baud ticks.
- Sits between the client logic and the UART TX. Uses the `tick` output of Uart_BaudRateGen as its time base.

---
 rtl/uart_tx_arbiter.sv | 126 ++++++++++++
 tb/tb_uart_tx_arbiter.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one UART transmitter among N_REQ requesters.
// Grants one byte per frame, waits for end of frame (or timeout), then enforces a tick-counted idle gap.
module uart_tx_arbiter #(
  parameter  int N_REQ         = 4,
  parameter  int DBIT          = 8,
  parameter  int GAP_TICKS     = 16,
  parameter  int TIMEOUT_TICKS = 176,
  parameter  int CNT_W         = 8,
  localparam int IDX_W         = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  tick,
  input  logic [N_REQ-1:0]      req,
  input  logic [N_REQ*DBIT-1:0] req_data,
  input  logic                  tx_done,
  output logic [N_REQ-1:0]      gnt,
  output logic                  tx_start,
  output logic [DBIT-1:0]       tx_data,
  output logic [IDX_W-1:0]      owner,
  output logic                  busy,
  output logic                  err
);

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_GAP} state_t;

  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_TICKS - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_TICKS - 1);
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(N_REQ - 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [IDX_W-1:0] r_last;

  logic [IDX_W-1:0] w_sel;
  logic             w_found;
  int               w_idx;

  // Scan downward so the candidate closest to last+1 is the final assignment.
  always_comb begin
    w_sel   = '0;
    w_found = 1'b0;
    w_idx   = 0;
    for (int k = N_REQ; k >= 1; k--) begin
      w_idx = int'(r_last) + k;
      if (w_idx >= N_REQ) w_idx = w_idx - N_REQ;
      if (req[w_idx]) begin
        w_sel   = IDX_W'(w_idx);
        w_found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_last   <= LAST_RST;
      gnt      <= '0;
      tx_start <= 1'b0;
      tx_data  <= '0;
      owner    <= '0;
      busy     <= 1'b0;
      err      <= 1'b0;
    end else begin
      gnt      <= '0;
      tx_start <= 1'b0;
      err      <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_found) begin
            tx_data  <= req_data[int'(w_sel)*DBIT +: DBIT];
            owner    <= w_sel;
            r_last   <= w_sel;
            gnt      <= N_REQ'(1) << w_sel;
            tx_start <= 1'b1;
            busy     <= 1'b1;
            r_state  <= S_START;
          end
        end
        S_START: begin
          r_cnt   <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          // tx_done takes precedence over a coincident final timeout tick.
          if (tx_done) begin
            r_cnt <= '0;
            if (GAP_TICKS == 0) begin
              r_state <= S_IDLE;
              busy    <= 1'b0;
            end else begin
              r_state <= S_GAP;
            end
          end else if (tick) begin
            if (r_cnt == TO_LAST) begin
              err   <= 1'b1;
              r_cnt <= '0;
              if (GAP_TICKS == 0) begin
                r_state <= S_IDLE;
                busy    <= 1'b0;
              end else begin
                r_state <= S_GAP;
              end
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        S_GAP: begin
          if (tick) begin
            if (r_cnt == GAP_LAST) begin
              r_cnt   <= '0;
              r_state <= S_IDLE;
              busy    <= 1'b0;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: vector table for grant order, scripted sequences for reset, gap, timeout, collision.
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        tick = 1'b0;
  logic [3:0]  req = '0;
  logic [31:0] req_data = '0;
  logic        tx_done = 1'b0;

  logic [3:0]  gnt, gnt0;
  logic        tx_start, tx_start0;
  logic [7:0]  tx_data, tx_data0;
  logic [1:0]  owner, owner0;
  logic        busy, busy0;
  logic        err, err0;

  int n_cmp  = 0;
  int n_fail = 0;
  bit quiet  = 1'b0;

  typedef struct {int idx; logic [7:0] data;} exp_t;
  exp_t exp_q[$];

  typedef struct {logic [3:0] req; logic [31:0] data; int idx;} vec_t;
  vec_t vecs[12];

  always #5 clk = ~clk;

  uart_tx_arbiter #(.N_REQ(4), .DBIT(8), .GAP_TICKS(16), .TIMEOUT_TICKS(176), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .tick(tick), .req(req), .req_data(req_data), .tx_done(tx_done),
    .gnt(gnt), .tx_start(tx_start), .tx_data(tx_data), .owner(owner), .busy(busy), .err(err)
  );

  uart_tx_arbiter #(.N_REQ(4), .DBIT(8), .GAP_TICKS(0), .TIMEOUT_TICKS(176), .CNT_W(8)) dut0 (
    .clk(clk), .reset(reset), .tick(tick), .req(req), .req_data(req_data), .tx_done(tx_done),
    .gnt(gnt0), .tx_start(tx_start0), .tx_data(tx_data0), .owner(owner0), .busy(busy0), .err(err0)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // Grant scoreboard: every grant pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (!reset && gnt !== 4'b0) begin
      n_cmp++;
      if (quiet || exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_gnt: got gnt=%b owner=%0d expected no grant", gnt, owner);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (gnt !== (4'b1 << e.idx) || owner !== 2'(e.idx) || tx_data !== e.data ||
            tx_start !== 1'b1 || busy !== 1'b1) begin
          n_fail++;
          $display("FAIL grant: got gnt=%b owner=%0d data=%h start=%b busy=%b expected gnt=%b owner=%0d data=%h start=1 busy=1",
                   gnt, owner, tx_data, tx_start, busy, 4'b1 << e.idx, e.idx, e.data);
        end else begin
          $display("grant owner=%0d data=%h", owner, tx_data);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_tick();
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    cyc();
  endtask

  task automatic push_exp(input int idx, input logic [31:0] data);
    exp_t e;
    e.idx  = idx;
    e.data = data[idx*8 +: 8];
    exp_q.push_back(e);
  endtask

  task automatic check_zero(input string name);
    chk(name, 32'({gnt, tx_start, tx_data, owner, busy, err}), 32'h0);
  endtask

  // Returns in the first WAIT_DONE cycle; optionally pulses tx_done during START.
  task automatic wait_gnt(input bit done_in_start);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 64 && !ok; i++) begin
      @(negedge clk);
      if (gnt !== 4'b0) ok = 1'b1;
    end
    chk("grant_seen", 32'(ok), 32'h1);
    if (done_in_start) tx_done = 1'b1;
    cyc();
    tx_done = 1'b0;
    chk("grant_one_cycle", 32'({gnt, tx_start, busy}), 32'h1);
  endtask

  task automatic gap_check(input string name);
    quiet = 1'b1;
    repeat (15) do_tick();
    chk({name, "_gap_busy"}, 32'(busy), 32'h1);
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    chk({name, "_gap_end"}, 32'(busy), 32'h0);
    quiet = 1'b0;
  endtask

  task automatic frame_done(input string name);
    tx_done = 1'b1;
    cyc();
    tx_done = 1'b0;
    gap_check(name);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{4'hF, 32'hA3A2A1A0, 1};
    vecs[1]  = '{4'hF, 32'hA3A2A1A0, 2};
    vecs[2]  = '{4'hF, 32'hA3A2A1A0, 3};
    vecs[3]  = '{4'hF, 32'hA3A2A1A0, 0};
    vecs[4]  = '{4'hF, 32'hA3A2A1A0, 1};
    vecs[5]  = '{4'hA, 32'h13121110, 3};
    vecs[6]  = '{4'hA, 32'h23222120, 1};
    vecs[7]  = '{4'h2, 32'h33323130, 1};
    vecs[8]  = '{4'h1, 32'h43424140, 0};
    vecs[9]  = '{4'hC, 32'h5A5B5C5D, 2};
    vecs[10] = '{4'h6, 32'hC3C2C1C0, 1};
    vecs[11] = '{4'h8, 32'hF0E1D2C3, 3};

    #2 reset = 1'b1;
    cyc();
    cyc();
    check_zero("reset_state");
    reset = 1'b0;
    cyc();

    req = 4'b0001;
    req_data = 32'h00000041;
    push_exp(0, req_data);
    wait_gnt(1'b0);
    req = 4'b0;
    repeat (5) do_tick();
    reset = 1'b1;
    #1;
    check_zero("reset_async_mid_frame");
    cyc();
    cyc();
    push_exp(0, req_data);
    req = 4'b0001;
    reset = 1'b0;
    wait_gnt(1'b0);
    req = 4'b0;
    tx_done = 1'b1;
    cyc();
    tx_done = 1'b0;
    chk("gap0_idle_after_done", 32'({busy0, busy}), 32'h1);
    gap_check("first");

    tx_done = 1'b1;
    cyc();
    tx_done = 1'b0;
    chk("done_in_idle", 32'(busy), 32'h0);

    req = 4'b0001;
    req_data = 32'h00000055;
    push_exp(0, req_data);
    wait_gnt(1'b1);
    req = 4'b0;
    repeat (20) do_tick();
    chk("done_in_start_ignored", 32'(busy), 32'h1);
    frame_done("start");

    foreach (vecs[i]) begin
      req = vecs[i].req;
      req_data = vecs[i].data;
      push_exp(vecs[i].idx, vecs[i].data);
      wait_gnt(1'b0);
      frame_done("vec");
    end
    req = 4'b0;

    req = 4'b0001;
    req_data = 32'h000000EE;
    push_exp(0, req_data);
    wait_gnt(1'b0);
    req = 4'b0;
    quiet = 1'b1;
    repeat (175) do_tick();
    chk("timeout_before_last", 32'({err, busy}), 32'h1);
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    chk("timeout_err", 32'(err), 32'h1);
    cyc();
    chk("timeout_err_one_cycle", 32'({err, busy}), 32'h1);
    gap_check("timeout");

    req = 4'b0001;
    req_data = 32'h00000077;
    push_exp(0, req_data);
    wait_gnt(1'b0);
    req = 4'b0;
    repeat (175) do_tick();
    tick = 1'b1;
    tx_done = 1'b1;
    cyc();
    tick = 1'b0;
    tx_done = 1'b0;
    chk("collision_no_err", 32'(err), 32'h0);
    cyc();
    chk("collision_no_err_late", 32'({err, busy}), 32'h1);
    gap_check("collision");

    repeat (4) cyc();
    chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
